// File: rtl/x_feed_buffer_pkg.sv
// ----------------------------------------------------------------------------
// x_feed_buffer_pkg
// Shared types and constants for the X-matrix feed buffer that sits in front
// of the 4-lane MAC ALU.
//   - state_t : buffer FSM states (EMPTY, FULL, STREAM)
//   - DATA_W  : width of one X element
//   - ROWS    : X rows per pass (ALU MAC length)
//   - COLS    : X columns (one per ALU lane)
//   - PASSES  : replays of the full matrix per load
//   - TOTAL   : ALU cycles per loaded matrix (ROWS*PASSES)
// ----------------------------------------------------------------------------
package x_feed_buffer_pkg;

    localparam int DATA_W  = 8;
    localparam int ROWS    = 8;
    localparam int COLS    = 4;
    localparam int PASSES  = 4;
    localparam int TOTAL   = ROWS * PASSES;
    localparam int ENTRIES = ROWS * COLS;

    // Counter widths: load_cnt/use_cnt cover 32 values, row_ptr covers 8.
    localparam int LOAD_W = 5;
    localparam int ROW_W  = 3;

    localparam logic [LOAD_W-1:0] LAST_LOAD = LOAD_W'(ENTRIES - 1);
    localparam logic [LOAD_W-1:0] LAST_USE  = LOAD_W'(TOTAL - 1);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL   = 2'd1,
        STREAM = 2'd2
    } state_t;

endpackage

// File: rtl/x_row_regfile.sv
// ----------------------------------------------------------------------------
// x_row_regfile
// 32 x DATA_W register file holding one 8x4 X matrix in row-major order.
// One byte write port, one row-wide (4 element) combinational read port.
// Ports:
//   clk    : clock
//   rst    : asynchronous active-low reset, clears all entries
//   we     : write enable
//   waddr  : write index (row = waddr[4:2], col = waddr[1:0])
//   wdata  : element to write
//   rrow   : row to read
//   rdata  : the 4 elements of row rrow, rdata[c] = column c
// ----------------------------------------------------------------------------
module x_row_regfile
    import x_feed_buffer_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we,
    input  logic [LOAD_W-1:0]             waddr,
    input  logic [DATA_W-1:0]             wdata,
    input  logic [ROW_W-1:0]              rrow,
    output logic [COLS-1:0][DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [ENTRIES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Row-major layout: the row index forms the upper address bits.
    always_comb begin
        rdata = '0;
        for (int c = 0; c < COLS; c++) begin
            rdata[c] = mem[{rrow, c[1:0]}];
        end
    end

endmodule

// File: rtl/x_feed_buffer.sv
// ----------------------------------------------------------------------------
// x_feed_buffer
// Loads one 8x4 X matrix as a serial byte stream, then replays its rows to
// the MAC ALU one row per ALU_en cycle, 4 passes (32 cycles), and frees
// itself for the next matrix.
// Ports:
//   clk        : clock
//   rst        : asynchronous active-low reset
//   in_valid   : input byte valid
//   in_data    : X element, row-major (row r col c at index 4r+c)
//   in_ready   : buffer accepts a byte this cycle (only while EMPTY)
//   ALU_en     : ALU enable; each high cycle consumes one row
//   X_reg1..4  : columns 0..3 of the current row, zero-extended by 1 bit
//   buf_full   : matrix loaded and not fully consumed
//   buf_done   : one-cycle pulse after the 32nd consume cycle
// ----------------------------------------------------------------------------
module x_feed_buffer
    import x_feed_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              ALU_en,
    output logic [DATA_W:0]   X_reg1,
    output logic [DATA_W:0]   X_reg2,
    output logic [DATA_W:0]   X_reg3,
    output logic [DATA_W:0]   X_reg4,
    output logic              buf_full,
    output logic              buf_done
);

    state_t                        state;
    logic [LOAD_W-1:0]             load_cnt;
    logic [LOAD_W-1:0]             use_cnt;
    logic [ROW_W-1:0]              row_ptr;
    logic                          load_we;
    logic [COLS-1:0][DATA_W-1:0]   row_data;

    // in_ready and buf_full decode straight from the state register, so they
    // carry no combinational path from any input.
    assign in_ready = (state == EMPTY);
    assign buf_full = (state != EMPTY);
    assign load_we  = in_valid & in_ready;

    x_row_regfile u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (load_we),
        .waddr (load_cnt),
        .wdata (in_data),
        .rrow  (row_ptr),
        .rdata (row_data)
    );

    // FSM and counters. row_ptr always points at the row the ALU sees in the
    // current cycle; a consume cycle advances it for the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= EMPTY;
            load_cnt <= '0;
            use_cnt  <= '0;
            row_ptr  <= '0;
            buf_done <= 1'b0;
        end else begin
            buf_done <= 1'b0;
            case (state)
                EMPTY: begin
                    // ALU_en here is a protocol violation and is ignored.
                    if (load_we) begin
                        if (load_cnt == LAST_LOAD) begin
                            load_cnt <= '0;
                            state    <= FULL;
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (ALU_en) begin
                        row_ptr <= row_ptr + 1'b1;
                        use_cnt <= use_cnt + 1'b1;
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    if (!ALU_en) begin
                        // ALU dropped out early: it clears its own counters,
                        // so rewind to row 0 and keep the matrix.
                        row_ptr <= '0;
                        use_cnt <= '0;
                        state   <= FULL;
                    end else if (use_cnt == LAST_USE) begin
                        row_ptr  <= '0;
                        use_cnt  <= '0;
                        buf_done <= 1'b1;
                        state    <= EMPTY;
                    end else begin
                        row_ptr <= row_ptr + 1'b1;
                        use_cnt <= use_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

    // Outputs are forced to zero while no matrix is held.
    always_comb begin
        X_reg1 = '0;
        X_reg2 = '0;
        X_reg3 = '0;
        X_reg4 = '0;
        if (state != EMPTY) begin
            X_reg1 = {1'b0, row_data[0]};
            X_reg2 = {1'b0, row_data[1]};
            X_reg3 = {1'b0, row_data[2]};
            X_reg4 = {1'b0, row_data[3]};
        end
    end

endmodule

// File: tb/tb_x_feed_buffer.sv
// ----------------------------------------------------------------------------
// tb_x_feed_buffer
// Self-checking bench for x_feed_buffer: a table-driven full run, directed
// corner-case sequences, and randomized load/stream traffic checked against
// a behavioural model of the buffer (matrix array, accept/consume counts).
// ----------------------------------------------------------------------------
module tb_x_feed_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       ALU_en;
    logic [8:0] X_reg1, X_reg2, X_reg3, X_reg4;
    logic       buf_full;
    logic       buf_done;

    always #5 clk = ~clk;

    x_feed_buffer dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .ALU_en   (ALU_en),
        .X_reg1   (X_reg1),
        .X_reg2   (X_reg2),
        .X_reg3   (X_reg3),
        .X_reg4   (X_reg4),
        .buf_full (buf_full),
        .buf_done (buf_done)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: the held matrix, how many bytes were accepted,
    // whether a full matrix is held, and how many rows have been consumed.
    logic [7:0] m_mem [32];
    bit         m_loaded;
    int         m_cnt;
    int         m_used;
    bit         m_done;

    // Outputs captured in the most recent cycle.
    logic [3:0][8:0] a_x;
    logic            a_ready, a_full, a_done;

    typedef struct {
        logic            en;
        logic [3:0][8:0] x;
        logic            done;
        logic            ready;
        logic            full;
    } vec_t;

    vec_t tbl [33];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] m_x(input int c);
        if (!m_loaded) return 9'd0;
        return {1'b0, m_mem[4 * (m_used % 8) + c]};
    endfunction

    task automatic capture();
        a_x     = {X_reg4, X_reg3, X_reg2, X_reg1};
        a_ready = in_ready;
        a_full  = buf_full;
        a_done  = buf_done;
    endtask

    // One clock cycle: drive inputs, sample on the falling edge and compare
    // with the model, then advance the model across the rising edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic en);
        bit done_n;
        in_valid = v;
        in_data  = d;
        ALU_en   = en;
        @(negedge clk);
        capture();
        chk("in_ready", 32'(a_ready), 32'(m_loaded ? 1'b0 : 1'b1));
        chk("buf_full", 32'(a_full), 32'(m_loaded));
        chk("buf_done", 32'(a_done), 32'(m_done));
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("X_reg%0d", c + 1), 32'(a_x[c]), 32'(m_x(c)));
        end
        done_n = 1'b0;
        if (!m_loaded) begin
            if (v) begin
                m_mem[m_cnt] = d;
                m_cnt++;
                if (m_cnt == 32) begin
                    m_loaded = 1'b1;
                    m_cnt    = 0;
                end
            end
        end else if (en) begin
            m_used++;
            if (m_used == 32) begin
                m_loaded = 1'b0;
                m_used   = 0;
                done_n   = 1'b1;
            end
        end else begin
            m_used = 0;
        end
        m_done = done_n;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        capture();
        chk("rst_in_ready", 32'(a_ready), 32'd1);
        chk("rst_buf_full", 32'(a_full), 32'd0);
        chk("rst_buf_done", 32'(a_done), 32'd0);
        chk("rst_X", 32'(a_x), 32'd0);
        for (int i = 0; i < 32; i++) m_mem[i] = 8'd0;
        m_loaded = 1'b0;
        m_cnt    = 0;
        m_used   = 0;
        m_done   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic load_seq(input int base, input bit gaps);
        int  i;
        bit  v;
        i = 0;
        while (i < 32) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            cycle(v, 8'(base + i), 1'b0);
            if (v) i++;
        end
    endtask

    task automatic stream(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 8'd0, 1'b1);
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        ALU_en   = 1'b0;
        #3;
        do_reset();

        // Full run, table driven.
        for (int k = 0; k < 32; k++) begin
            tbl[k].en = 1'b1;
            for (int c = 0; c < 4; c++) tbl[k].x[c] = 9'(4 * (k % 8) + c);
            tbl[k].done  = 1'b0;
            tbl[k].ready = 1'b0;
            tbl[k].full  = 1'b1;
        end
        tbl[32].en    = 1'b0;
        tbl[32].x     = '0;
        tbl[32].done  = 1'b1;
        tbl[32].ready = 1'b1;
        tbl[32].full  = 1'b0;

        load_seq(0, 1'b0);
        for (int k = 0; k < 33; k++) begin
            cycle(1'b0, 8'd0, tbl[k].en);
            chk($sformatf("tbl%0d_x", k), 32'(a_x), 32'(tbl[k].x));
            chk($sformatf("tbl%0d_done", k), 32'(a_done), 32'(tbl[k].done));
            chk($sformatf("tbl%0d_ready", k), 32'(a_ready), 32'(tbl[k].ready));
            chk($sformatf("tbl%0d_full", k), 32'(a_full), 32'(tbl[k].full));
        end

        // All-ones data: zero extension on every stream cycle, zero in EMPTY.
        for (int i = 0; i < 32; i++) cycle(1'b1, 8'hFF, 1'b0);
        for (int k = 0; k < 32; k++) begin
            cycle(1'b0, 8'd0, 1'b1);
            chk("ff_X1", 32'(a_x[0]), 32'h0FF);
            chk("ff_X4", 32'(a_x[3]), 32'h0FF);
        end
        cycle(1'b0, 8'd0, 1'b0);
        chk("ff_empty_X", 32'(a_x), 32'd0);
        cycle(1'b0, 8'd0, 1'b1);
        cycle(1'b0, 8'd0, 1'b1);
        chk("en_in_empty_X", 32'(a_x), 32'd0);
        chk("en_in_empty_full", 32'(a_full), 32'd0);

        // Abort after 10 consumes, then a complete restart.
        load_seq(0, 1'b1);
        stream(10);
        cycle(1'b0, 8'd0, 1'b0);
        cycle(1'b0, 8'd0, 1'b0);
        chk("abort_full", 32'(a_full), 32'd1);
        chk("abort_ready", 32'(a_ready), 32'd0);
        chk("abort_done", 32'(a_done), 32'd0);
        cycle(1'b0, 8'd0, 1'b1);
        chk("restart_row0", 32'(a_x), 32'({9'd3, 9'd2, 9'd1, 9'd0}));
        for (int k = 1; k < 32; k++) begin
            cycle(1'b0, 8'd0, 1'b1);
            chk("restart_no_done", 32'(a_done), 32'd0);
        end
        cycle(1'b0, 8'd0, 1'b0);
        chk("restart_done", 32'(a_done), 32'd1);

        // Backpressure: bytes offered during FULL and STREAM are dropped.
        load_seq(0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 8'hAA, 1'b0);
            chk("bp_full_ready", 32'(a_ready), 32'd0);
        end
        for (int k = 0; k < 32; k++) begin
            cycle(1'b1, 8'hAA, 1'b1);
            chk("bp_stream_ready", 32'(a_ready), 32'd0);
            if (k == 2) chk("bp_row2", 32'(a_x), 32'({9'd11, 9'd10, 9'd9, 9'd8}));
        end
        cycle(1'b0, 8'd0, 1'b0);

        // Reset mid-load, then a fresh matrix 50..81.
        for (int i = 0; i < 13; i++) cycle(1'b1, 8'(200 + i), 1'b0);
        do_reset();
        for (int i = 0; i < 31; i++) cycle(1'b1, 8'(50 + i), 1'b0);
        cycle(1'b0, 8'd0, 1'b0);
        chk("rl_full_31", 32'(a_full), 32'd0);
        cycle(1'b1, 8'd81, 1'b0);
        cycle(1'b0, 8'd0, 1'b0);
        chk("rl_full_32", 32'(a_full), 32'd1);
        cycle(1'b0, 8'd0, 1'b1);
        chk("rl_row0", 32'(a_x), 32'({9'd53, 9'd52, 9'd51, 9'd50}));
        stream(31);
        cycle(1'b0, 8'd0, 1'b0);

        // Back-to-back: next matrix offered through the buf_done cycle.
        load_seq(0, 1'b0);
        stream(31);
        cycle(1'b1, 8'd100, 1'b1);
        cycle(1'b1, 8'd100, 1'b0);
        chk("b2b_done", 32'(a_done), 32'd1);
        chk("b2b_ready", 32'(a_ready), 32'd1);
        for (int i = 1; i < 32; i++) cycle(1'b1, 8'(100 + i), 1'b0);
        cycle(1'b0, 8'd0, 1'b1);
        chk("b2b_row0", 32'(a_x), 32'({9'd103, 9'd102, 9'd101, 9'd100}));
        stream(31);
        cycle(1'b0, 8'd0, 1'b0);

        // Randomized traffic against the model.
        for (int it = 0; it < 20; it++) begin
            int budget;
            int abort_at;
            int n;
            if (it % 7 == 3) begin
                for (int i = 0; i < int'($urandom_range(1, 20)); i++)
                    cycle(1'($urandom), 8'($urandom), 1'b0);
                do_reset();
            end
            budget = 0;
            while (!m_loaded && budget < 200) begin
                cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 7) == 0));
                budget++;
            end
            chk("rnd_loaded", 32'(m_loaded), 32'd1);
            abort_at = $urandom_range(0, 60);
            n = 0;
            budget = 0;
            while (m_loaded && budget < 200) begin
                logic en;
                en = (n == abort_at) ? 1'b0 : ($urandom_range(0, 9) != 0 || n > abort_at);
                cycle(1'($urandom), 8'($urandom), en);
                n++;
                budget++;
            end
            chk("rnd_consumed", 32'(m_loaded), 32'd0);
            cycle(1'b0, 8'd0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
